// File: rtl/dmux8way16_buf.sv
// Registered 1-to-8 demultiplexer with a one-entry valid/ready buffer per lane.
// Optional macro DMUX_AUTOSEL_EN adds an AUTO input and a round-robin lane pointer.
module dmux8way16_buf #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] IN,
  input  logic [2:0]       SEL,
`ifdef DMUX_AUTOSEL_EN
  input  logic             AUTO,
`endif
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] H,
  output logic [7:0]       VALID,
  input  logic [7:0]       READY,
  output logic [3:0]       OCC
);

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [7:0]       valid_q, valid_d;
  logic [3:0]       occ_q, occ_d;
  logic [2:0]       esel;
  logic             acc;
  logic             inc;
  logic [7:0]       drn;
  logic [7:0]       load;
  logic [3:0]       dec_cnt;

`ifdef DMUX_AUTOSEL_EN
  logic [2:0] ptr_q, ptr_d;

  always_comb begin
    esel  = AUTO ? ptr_q : SEL;
    ptr_d = (acc && AUTO) ? ptr_q + 3'd1 : ptr_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= 3'd0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb esel = SEL;
`endif

  // A lane reloaded by an accept in the same cycle as its drain stays valid.
  always_comb begin
    IN_READY = ~valid_q[esel] | READY[esel];
    acc      = IN_VALID & IN_READY;
    drn      = valid_q & READY;
    load     = acc ? (8'b1 << esel) : 8'b0;
    valid_d  = (valid_q & ~drn) | load;
    inc      = acc & ~valid_q[esel];
    dec_cnt  = 4'd0;
    for (int k = 0; k < 8; k++) begin
      dec_cnt   = dec_cnt + {3'b000, drn[k] & ~load[k]};
      data_d[k] = load[k] ? IN : data_q[k];
    end
    occ_d = occ_q + {3'b000, inc} - dec_cnt;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 8'h00;
      occ_q   <= 4'd0;
      for (int k = 0; k < 8; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int k = 0; k < 8; k++) data_q[k] <= data_d[k];
    end
  end

  assign A     = data_q[0];
  assign B     = data_q[1];
  assign C     = data_q[2];
  assign D     = data_q[3];
  assign E     = data_q[4];
  assign F     = data_q[5];
  assign G     = data_q[6];
  assign H     = data_q[7];
  assign VALID = valid_q;
  assign OCC   = occ_q;

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Directed and random checks of dmux8way16_buf against a per-lane buffer model.
// Build with DMUX_AUTOSEL_EN defined to also exercise the round-robin pointer.
module tb_dmux8way16_buf;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_r;
  logic [2:0]  sel_r;
  logic        in_valid_r;
  logic        in_ready;
  logic [15:0] a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o;
  logic [7:0]  valid_o;
  logic [7:0]  ready_r;
  logic [3:0]  occ_o;
`ifdef DMUX_AUTOSEL_EN
  logic        auto_r;
  int          mptr;
`endif

  logic [15:0] mdata [8];
  logic [7:0]  mvalid;
  int          n_cmp;
  int          n_err;

  dmux8way16_buf #(.WIDTH(16)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .IN       (in_r),
    .SEL      (sel_r),
`ifdef DMUX_AUTOSEL_EN
    .AUTO     (auto_r),
`endif
    .IN_VALID (in_valid_r),
    .IN_READY (in_ready),
    .A        (a_o),
    .B        (b_o),
    .C        (c_o),
    .D        (d_o),
    .E        (e_o),
    .F        (f_o),
    .G        (g_o),
    .H        (h_o),
    .VALID    (valid_o),
    .READY    (ready_r),
    .OCC      (occ_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_esel();
`ifdef DMUX_AUTOSEL_EN
    if (auto_r) return mptr[2:0];
`endif
    return sel_r;
  endfunction

  function automatic logic model_ready();
    logic [2:0] es;
    es = model_esel();
    return !mvalid[es] || ready_r[es];
  endfunction

  task automatic model_reset();
    mvalid = 8'h00;
    for (int k = 0; k < 8; k++) mdata[k] = 16'h0000;
`ifdef DMUX_AUTOSEL_EN
    mptr = 0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] lanes [8];
    lanes = '{a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o};
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s.lane%0d", tag, k), {16'h0, lanes[k]}, {16'h0, mdata[k]});
    chk({tag, ".valid"}, {24'h0, valid_o}, {24'h0, mvalid});
    chk({tag, ".occ"}, {28'h0, occ_o}, $countones(mvalid));
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic cycle(input string tag);
    logic [2:0] es;
    logic       acc;
    #1;
    chk({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, model_ready()});
    @(posedge clk);
    es  = model_esel();
    acc = in_valid_r && model_ready();
    for (int k = 0; k < 8; k++) begin
      if (acc && es == k) begin
        mdata[k]  = in_r;
        mvalid[k] = 1'b1;
      end else if (mvalid[k] && ready_r[k]) begin
        mvalid[k] = 1'b0;
      end
    end
`ifdef DMUX_AUTOSEL_EN
    if (acc && auto_r) mptr = (mptr + 1) % 8;
`endif
    if (acc) $display("%s: word %h -> lane %0d", tag, in_r, es);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_lane(input logic [2:0] s, input logic [15:0] d);
    in_valid_r = 1'b1;
    sel_r      = s;
    in_r       = d;
    cycle("load");
    in_valid_r = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_r = 16'h0;
    sel_r = 3'd0;
    in_valid_r = 1'b0;
    ready_r = 8'h00;
`ifdef DMUX_AUTOSEL_EN
    auto_r = 1'b0;
`endif
    model_reset();
    #12;
    chk("reset.in_ready", {31'h0, in_ready}, 32'h1);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-operation with two lanes loaded.
    load_lane(3'd1, 16'h1111);
    load_lane(3'd6, 16'h6666);
    chk("areset.pre_valid", {24'h0, valid_o}, 32'h42);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    chk("areset.in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("areset.in_ready_after", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    // Fill all lanes with a walking one while consumers stall.
    ready_r = 8'h00;
    for (int i = 0; i < 8; i++) load_lane(i[2:0], 16'h1 << i);
    chk("sweep.valid", {24'h0, valid_o}, 32'hFF);
    chk("sweep.occ", {28'h0, occ_o}, 32'h8);
    chk("sweep.h", {16'h0, h_o}, 32'h80);
    in_valid_r = 1'b1;
    sel_r = 3'd3;
    in_r = 16'hDEAD;
    #1 chk("sweep.full_in_ready", {31'h0, in_ready}, 32'h0);
    cycle("sweep.full");
    chk("sweep.d_held", {16'h0, d_o}, 32'h0008);
    in_valid_r = 1'b0;

    // Pass-through on lane C.
    do_reset();
    load_lane(3'd2, 16'h1234);
    ready_r = 8'h04;
    in_valid_r = 1'b1;
    sel_r = 3'd2;
    in_r = 16'hBEEF;
    #1 chk("pass.in_ready", {31'h0, in_ready}, 32'h1);
    cycle("pass");
    chk("pass.c", {16'h0, c_o}, 32'hBEEF);
    chk("pass.occ", {28'h0, occ_o}, 32'h1);
    in_valid_r = 1'b0;
    ready_r = 8'h00;

    // Accept into B while F drains.
    do_reset();
    load_lane(3'd0, 16'h000A);
    load_lane(3'd5, 16'h000F);
    ready_r = 8'h20;
    in_valid_r = 1'b1;
    sel_r = 3'd1;
    in_r = 16'h00AA;
    cycle("conc");
    chk("conc.valid", {24'h0, valid_o}, 32'h03);
    chk("conc.occ", {28'h0, occ_o}, 32'h2);
    in_valid_r = 1'b0;
    ready_r = 8'h00;

    // Sustained backpressure on lane E.
    do_reset();
    load_lane(3'd4, 16'h5555);
    in_valid_r = 1'b1;
    sel_r = 3'd4;
    for (int c = 0; c < 10; c++) begin
      in_r = (c % 2 == 1) ? 16'hAAAA : 16'h1234;
      cycle("bp");
      chk("bp.e", {16'h0, e_o}, 32'h5555);
    end
    ready_r = 8'h10;
    in_r = 16'h7777;
    #1 chk("bp.release_ready", {31'h0, in_ready}, 32'h1);
    cycle("bp.release");
    chk("bp.e_new", {16'h0, e_o}, 32'h7777);
    in_valid_r = 1'b0;
    ready_r = 8'h00;

`ifdef DMUX_AUTOSEL_EN
    // Round-robin steering ignores SEL.
    do_reset();
    auto_r = 1'b1;
    ready_r = 8'hFF;
    sel_r = 3'd7;
    in_valid_r = 1'b1;
    for (int w = 0; w < 10; w++) begin
      in_r = w[15:0];
      cycle("auto");
    end
    chk("auto.a", {16'h0, a_o}, 32'h8);
    chk("auto.b", {16'h0, b_o}, 32'h9);
    chk("auto.h", {16'h0, h_o}, 32'h7);
    in_r = 16'hC0DE;
    cycle("auto.ptr");
    chk("auto.ptr_c", {16'h0, c_o}, 32'hC0DE);
    in_valid_r = 1'b0;
    auto_r = 1'b0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      in_valid_r = ($urandom_range(0, 3) != 0);
      sel_r      = 3'($urandom_range(0, 7));
      in_r       = 16'($urandom);
      ready_r    = 8'($urandom);
`ifdef DMUX_AUTOSEL_EN
      auto_r     = ($urandom_range(0, 1) == 1);
`endif
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmux8way16_buf.md
Name: dmux8way16_buf

Overview:
- Registered 1-to-8 demultiplexer for 16-bit words; inverse of the 8-way 16-bit mux.
- Accepts a stream of words on IN with a valid/ready handshake and steers each word to one of eight output lanes A..H, selected by SEL.
- Each lane holds one registered entry with its own valid/ready handshake, so lanes drain independently.
- Sits between a single producer and eight consumers, e.g. a write-back fan-out.

Parameters:
- WIDTH, 16, data width of IN and of each lane A..H.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN  input  WIDTH  input data word.
- SEL  input  3  destination lane: 0=A, 1=B, ... 7=H.
- IN_VALID  input  1  producer has a word on IN/SEL.
- IN_READY  output  1  block can accept the word this cycle.
- A, B, C, D, E, F, G, H  output  WIDTH each  lane data registers.
- VALID  output  8  per-lane entry valid; bit k is lane k (bit 0 = A).
- READY  input  8  per-lane consumer ready; bit k is lane k.
- OCC  output  4  registered count of valid lanes, range 0..8.

Behaviour:
- Reset (RST_N low, asynchronous, any time including mid-transfer):
  - A..H = 0, VALID = 8'h00, OCC = 0.
  - Internal select pointer = 0 (see Optional Feature).
  - IN_READY reads 1 while in reset and after reset.
- Effective select: esel = SEL (or the pointer, see Optional Feature).
- IN_READY is combinational: IN_READY = ~VALID[esel] | READY[esel].
- Accept condition: acc = IN_VALID & IN_READY. IN and SEL are sampled only when acc=1; SEL may change freely otherwise.
- Drain condition per lane k: drn[k] = VALID[k] & READY[k].
- Lane k update at each rising edge:
  - If acc and esel==k: lane data <= IN and VALID[k] <= 1. This applies even if drn[k]=1 in the same cycle (pass-through: old entry consumed, new entry loaded).
  - Else if drn[k]: VALID[k] <= 0. Lane data keeps its last value and is qualified by VALID only.
  - Else: hold.
- Latency: a word accepted in cycle n is visible on its lane with VALID set in cycle n+1.
- Throughput: one word per cycle when the target lane is empty or draining.
- Lane data is never modified while VALID[k]=1 and READY[k]=0. Full backpressure stability is mandatory.
- OCC: OCC <= OCC + inc - dec, where:
  - inc = acc & ~VALID[esel] (accept into an empty lane);
  - dec = number of lanes with drn[k] and not reloaded by acc in the same cycle.
  - OCC always equals the popcount of VALID; it never exceeds 8 and never underflows.
- Simultaneous events:
  - Accept into lane j while other lanes drain: all updates occur in the same cycle, with no priority conflict.
  - All 8 lanes full with READY = 0: IN_READY = 0 for every esel.
- With IN_VALID=0, no lane is written. READY on an empty lane has no effect.

Optional Feature:
- Macro: DMUX_AUTOSEL_EN.
- Defined:
  - Adds input port AUTO (1 bit, after SEL).
  - Internal 3-bit pointer PTR, reset to 0.
  - When AUTO=1: esel = PTR, SEL is ignored, and PTR <= PTR+1 (wraps 7->0) on every acc.
  - When AUTO=0: esel = SEL and PTR holds.
  - A stalled lane (IN_READY=0 at PTR) blocks the stream; lanes are not skipped.
- Not defined: no AUTO port, no PTR, esel = SEL.

Test Plan:
- Reset: load lanes 1 and 6, then pull RST_N low between clock edges -> VALID=00, OCC=0, A..H=0000 immediately without a clock edge; IN_READY=1 after release.
- Sweep: READY=00, send IN=1<<i with SEL=i for i=0..7, one per cycle -> A=0001, B=0002, ... H=0080, VALID=FF, OCC=8; then IN_VALID=1, SEL=3 -> IN_READY=0, D stays 0008.
- Pass-through: lane C holds 1234 with VALID[2]=1; READY[2]=1, IN=BEEF, SEL=2 -> IN_READY=1; next cycle C=BEEF, VALID[2]=1, OCC unchanged.
- Concurrent: lanes A and F valid; accept IN=00AA to SEL=1 while READY=8'h20 -> next cycle B=00AA, VALID=8'h03, OCC=2.
- Backpressure: lane E holds 5555 with READY[4]=0 for 10 cycles while IN toggles with SEL=4 and IN_VALID=1 -> E=5555 and IN_READY=0 every cycle; raise READY[4] -> a word is accepted that cycle.
- (DMUX_AUTOSEL_EN) AUTO=1, READY=FF, send 10 words 0..9 -> A..H receive 0..7 in order, then A=0008, B=0009; PTR=2 at end; SEL held at 7 throughout has no effect.
